// File: rtl/str_sdiv.sv
// str_sdiv: pipelined signed divider around the str_usdiv core.
// Ports: clk, rst (sync, active-high); in_* operand stream
//   (dividend, divisor, last, valid/ready); out_* result stream
//   (quotient, remainder, last, valid/ready); out_dbz/out_ovf
//   exist only when STR_SDIV_EXC_EN is defined (saturating
//   exception results). Latency DW-PRESHIFT+2, one result/cycle.

module str_usdiv #(
  parameter int DW       = 8,
  parameter int PRESHIFT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_dividend,
  input  logic [DW-1:0] in_divisor,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_quotient,
  output logic [DW-1:0] out_remainder,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int STG = DW - PRESHIFT;

  logic [STG:0]   sv;
  logic [STG:0]   sl;
  logic [STG+1:1] rdy;
  logic [DW-1:0]  srem [STG+1];
  logic [DW-1:0]  sq   [STG+1];
  logic [DW-1:0]  sdiv [STG];

  assign sv[0]   = in_valid;
  assign sl[0]   = in_last;
  assign srem[0] = in_dividend;
  assign sq[0]   = '0;
  assign sdiv[0] = in_divisor;

  assign in_ready      = rdy[1];
  assign rdy[STG+1]    = out_ready;
  assign out_valid     = sv[STG];
  assign out_last      = sl[STG];
  assign out_quotient  = sq[STG];
  assign out_remainder = srem[STG];

  // Stage k resolves quotient bit STG-k by a restoring
  // compare of the partial remainder against b << bit.
  for (genvar k = 1; k <= STG; k++) begin : g_stg
    localparam int SH = STG - k;

    logic            v_q;
    logic            lst_q;
    logic [DW-1:0]   rem_q;
    logic [DW-1:0]   quo_q;
    logic [DW-1:0]   rem_d;
    logic [DW-1:0]   quo_d;
    logic [2*DW-1:0] bsh;
    logic            ge;

    assign bsh = {{DW{1'b0}}, sdiv[k-1]} << SH;
    assign ge  = {{DW{1'b0}}, srem[k-1]} >= bsh;

    // ge implies bsh < 2^DW, so its low half is exact.
    assign rem_d = ge ? srem[k-1] - bsh[DW-1:0]
                      : srem[k-1];
    assign quo_d = sq[k-1]
                 | ({{(DW-1){1'b0}}, ge} << SH);

    assign rdy[k] = ~v_q | rdy[k+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        lst_q <= 1'b0;
        rem_q <= '0;
        quo_q <= '0;
      end else if (rdy[k]) begin
        v_q <= sv[k-1];
        if (sv[k-1]) begin
          lst_q <= sl[k-1];
          rem_q <= rem_d;
          quo_q <= quo_d;
        end
      end
    end

    assign sv[k]   = v_q;
    assign sl[k]   = lst_q;
    assign srem[k] = rem_q;
    assign sq[k]   = quo_q;

    // The last stage has no consumer for the divisor.
    if (k < STG) begin : g_d
      logic [DW-1:0] div_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          div_q <= '0;
        end else if (rdy[k] && sv[k-1]) begin
          div_q <= sdiv[k-1];
        end
      end
      assign sdiv[k] = div_q;
    end
  end

endmodule

module str_sdiv #(
  parameter int DW       = 8,
  parameter int PRESHIFT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_dividend,
  input  logic [DW-1:0] in_divisor,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_quotient,
  output logic [DW-1:0] out_remainder,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
`ifdef STR_SDIV_EXC_EN
  ,
  output logic          out_dbz,
  output logic          out_ovf
`endif
);

  localparam int STG   = DW - PRESHIFT;
  localparam int AW    = $clog2(STG + 1);
  localparam int DEPTH = 1 << AW;
`ifdef STR_SDIV_EXC_EN
  localparam int FW = 4;
  localparam logic [DW-1:0] MINV =
    {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MAXV =
    {1'b0, {(DW-1){1'b1}}};
`else
  localparam int FW = 2;
`endif

  // Flag bits: 0 rneg, 1 qneg, 2 dbz, 3 ovf.
  logic          pre_v_q;
  logic          pre_l_q;
  logic [DW-1:0] pre_a_q;
  logic [DW-1:0] pre_b_q;
  logic [FW-1:0] pre_f_q;
  logic [FW-1:0] pre_f_d;
  logic [DW-1:0] a_mag;
  logic [DW-1:0] b_mag;
  logic          pre_rdy;

  logic          core_rdy;
  logic          core_v;
  logic          core_l;
  logic [DW-1:0] core_q;
  logic [DW-1:0] core_r;

  logic [FW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic          fifo_push;
  logic          fifo_pop;
  logic [FW-1:0] fh;

  logic          post_rdy;
  logic          out_v_q;
  logic          out_l_q;
  logic [DW-1:0] out_q_q;
  logic [DW-1:0] out_r_q;
  logic [DW-1:0] q_d;
  logic [DW-1:0] r_d;
`ifdef STR_SDIV_EXC_EN
  logic          dbz_q;
  logic          ovf_q;
`endif

  // The most negative value negates to itself, which as an
  // unsigned DW-bit number is exactly its magnitude.
  assign a_mag = in_dividend[DW-1]
               ? {DW{1'b0}} - in_dividend : in_dividend;
  assign b_mag = in_divisor[DW-1]
               ? {DW{1'b0}} - in_divisor : in_divisor;

  always_comb begin
    pre_f_d    = '0;
    pre_f_d[0] = in_dividend[DW-1];
    pre_f_d[1] = in_dividend[DW-1] ^ in_divisor[DW-1];
`ifdef STR_SDIV_EXC_EN
    pre_f_d[2] = (in_divisor == '0);
    pre_f_d[3] = (in_dividend == MINV)
               && (in_divisor == '1);
`endif
  end

  assign pre_rdy  = ~pre_v_q | core_rdy;
  assign in_ready = pre_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_v_q <= 1'b0;
      pre_l_q <= 1'b0;
      pre_a_q <= '0;
      pre_b_q <= '0;
      pre_f_q <= '0;
    end else if (pre_rdy) begin
      pre_v_q <= in_valid;
      if (in_valid) begin
        pre_l_q <= in_last;
        pre_a_q <= a_mag;
        pre_b_q <= b_mag;
        pre_f_q <= pre_f_d;
      end
    end
  end

  str_usdiv #(
    .DW       (DW),
    .PRESHIFT (PRESHIFT)
  ) u_core (
    .clk           (clk),
    .rst           (rst),
    .in_dividend   (pre_a_q),
    .in_divisor    (pre_b_q),
    .in_last       (pre_l_q),
    .in_valid      (pre_v_q),
    .in_ready      (core_rdy),
    .out_quotient  (core_q),
    .out_remainder (core_r),
    .out_last      (core_l),
    .out_valid     (core_v),
    .out_ready     (post_rdy)
  );

  // Sign flags travel beside the core; at most STG items
  // are ever inside it, so DEPTH > STG cannot overflow.
  assign fifo_push = pre_v_q & core_rdy;
  assign fifo_pop  = core_v & post_rdy;
  assign fh        = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (!rst && fifo_push) begin
      mem_q[wp_q] <= pre_f_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (fifo_push) begin
        wp_q <= wp_q + AW'(1);
      end
      if (fifo_pop) begin
        rp_q <= rp_q + AW'(1);
      end
    end
  end

  always_comb begin
    q_d = fh[1] ? {DW{1'b0}} - core_q : core_q;
    r_d = fh[0] ? {DW{1'b0}} - core_r : core_r;
`ifdef STR_SDIV_EXC_EN
    if (fh[2]) begin
      q_d = fh[0] ? MINV : MAXV;
    end else if (fh[3]) begin
      q_d = MAXV;
      r_d = '0;
    end
`endif
  end

  assign post_rdy = ~out_v_q | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q <= 1'b0;
      out_l_q <= 1'b0;
      out_q_q <= '0;
      out_r_q <= '0;
    end else if (post_rdy) begin
      out_v_q <= core_v;
      if (core_v) begin
        out_l_q <= core_l;
        out_q_q <= q_d;
        out_r_q <= r_d;
      end
    end
  end

`ifdef STR_SDIV_EXC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (post_rdy && core_v) begin
      dbz_q <= fh[2];
      ovf_q <= fh[3];
    end
  end

  assign out_dbz = dbz_q;
  assign out_ovf = ovf_q;
`endif

  assign out_valid     = out_v_q;
  assign out_last      = out_l_q;
  assign out_quotient  = out_q_q;
  assign out_remainder = out_r_q;

endmodule
